// File: rtl/status_flag_unit_pkg.sv
// Shared types and encodings for the condition-code unit.
package status_flag_unit_pkg;

    typedef logic [2:0] flags_t;

    typedef enum logic [2:0] {
        JT_NONE = 3'b000,
        JT_JZ   = 3'b001,
        JT_JN   = 3'b010,
        JT_JC   = 3'b011,
        JT_JMP  = 3'b100
    } jump_t;

    // Flag bits share their positions in the execute status word.
    localparam int unsigned ST_VALID = 3;
    localparam int unsigned ST_C     = 2;
    localparam int unsigned ST_N     = 1;
    localparam int unsigned ST_Z     = 0;

endpackage

// File: rtl/status_flag_unit_if.sv
// Execute-to-flag-unit signal bundle; master drives the instruction side.
interface status_flag_unit_if;
    import status_flag_unit_pkg::*;

    logic       Stall;
    logic [3:0] newStatus;
    logic       FlagWriteEn;
    logic [2:0] FlagMask;
    logic       SetCarry;
    logic       ClrCarry;
    logic [2:0] JumpType;
    logic       IntSave;
    logic       IntRestore;
    flags_t     Flags;
    logic       TakeBranch;
    logic       FlushQ;
    logic       StackOverflow;
    logic       StackUnderflow;

    modport master (
        output Stall, newStatus, FlagWriteEn, FlagMask, SetCarry, ClrCarry,
               JumpType, IntSave, IntRestore,
        input  Flags, TakeBranch, FlushQ, StackOverflow, StackUnderflow
    );

    modport slave (
        input  Stall, newStatus, FlagWriteEn, FlagMask, SetCarry, ClrCarry,
               JumpType, IntSave, IntRestore,
        output Flags, TakeBranch, FlushQ, StackOverflow, StackUnderflow
    );

endinterface

// File: rtl/flag_shadow_stack.sv
// CCR shadow stack for nested interrupts with sticky overflow/underflow.
module flag_shadow_stack
    import status_flag_unit_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 2,
    parameter int unsigned PTR_W       = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   stall,
    input  logic   push,
    input  logic   pop,
    input  flags_t pushData,
    output flags_t popData,
    output logic   empty,
    output logic   full,
    output logic   overflow,
    output logic   underflow
);

    // Pointer carries one extra bit so it can reach STACK_DEPTH (full).
    localparam logic [PTR_W:0] ONE       = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(STACK_DEPTH);

    logic [PTR_W:0] ptr;
    logic [PTR_W:0] topIdx;
    flags_t         mem [STACK_DEPTH];
    logic           doPush;
    logic           doPop;

    assign empty   = (ptr == '0);
    assign full    = (ptr == DEPTH_CNT);
    assign topIdx  = ptr - ONE;
    assign popData = mem[topIdx[PTR_W-1:0]];
    // A simultaneous restore wins; the push is silently dropped.
    assign doPush  = push && !pop && !stall;
    assign doPop   = pop && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (doPop) begin
            if (empty) begin
                underflow <= 1'b1;
            end else begin
                ptr <= topIdx;
            end
        end else if (doPush) begin
            if (full) begin
                overflow <= 1'b1;
            end else begin
                mem[ptr[PTR_W-1:0]] <= pushData;
                ptr                 <= ptr + ONE;
            end
        end
    end

endmodule

// File: rtl/status_flag_unit.sv
// Condition-code register: masked ALU merge, carry ops, branch resolve
// against bypassed flags, and interrupt save/restore.
module status_flag_unit
    import status_flag_unit_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 2,
    parameter int unsigned PTR_W       = 1
) (
    input  logic               clk,
    input  logic               rst,
    status_flag_unit_if.slave  bus
);

    flags_t flagsQ;
    flags_t merged;
    flags_t ef;
    flags_t nextFlags;
    flags_t popData;
    logic   aluWrite;
    logic   condHit;
    logic   takeBranch;
    logic   flushQ;
    logic   stackEmpty;
    logic   stackFull;
    logic   overflow;
    logic   underflow;

    flag_shadow_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .PTR_W       (PTR_W)
    ) uStack (
        .clk       (clk),
        .rst       (rst),
        .stall     (bus.Stall),
        .push      (bus.IntSave),
        .pop       (bus.IntRestore),
        .pushData  (flagsQ),
        .popData   (popData),
        .empty     (stackEmpty),
        .full      (stackFull),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always_comb begin
        aluWrite = bus.FlagWriteEn && bus.newStatus[ST_VALID];
        for (int unsigned i = 0; i < 3; i++) begin
            merged[i] = bus.FlagMask[i] ? bus.newStatus[i] : flagsQ[i];
        end
        ef = aluWrite ? merged : flagsQ;

        condHit = 1'b0;
        case (bus.JumpType)
            JT_JZ:   condHit = ef[ST_Z];
            JT_JN:   condHit = ef[ST_N];
            JT_JC:   condHit = ef[ST_C];
            JT_JMP:  condHit = 1'b1;
            default: condHit = 1'b0;
        endcase
        takeBranch = condHit && !bus.Stall && !rst;

        // Steps layer in priority order: jump clear, carry ops, restore.
        nextFlags = ef;
        if (takeBranch) begin
            case (bus.JumpType)
                JT_JZ:   nextFlags[ST_Z] = 1'b0;
                JT_JN:   nextFlags[ST_N] = 1'b0;
                JT_JC:   nextFlags[ST_C] = 1'b0;
                default: ;
            endcase
        end
        if (bus.SetCarry) nextFlags[ST_C] = 1'b1;
        if (bus.ClrCarry) nextFlags[ST_C] = 1'b0;
        if (bus.IntRestore && !stackEmpty) nextFlags = popData;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flagsQ <= '0;
            flushQ <= 1'b0;
        end else begin
            flushQ <= takeBranch;
            if (!bus.Stall) begin
                flagsQ <= nextFlags;
            end
        end
    end

    assign bus.Flags          = flagsQ;
    assign bus.TakeBranch     = takeBranch;
    assign bus.FlushQ         = flushQ;
    assign bus.StackOverflow  = overflow;
    assign bus.StackUnderflow = underflow;

    logic unusedFull;
    assign unusedFull = stackFull;

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed bench for status_flag_unit with a reference model checked every cycle.
module tb_status_flag_unit;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    status_flag_unit_if bus ();

    status_flag_unit #(
        .STACK_DEPTH (DEPTH),
        .PTR_W       (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: flags as three named bits, stack as a queue.
    logic       mC, mN, mZ;
    logic [2:0] mStk[$];
    logic       mOvf, mUnf, mFlush;

    function automatic logic [2:0] bypassFlags();
        logic [2:0] cur;
        cur = {mC, mN, mZ};
        if (bus.FlagWriteEn && bus.newStatus[3])
            return (bus.newStatus[2:0] & bus.FlagMask) | (cur & ~bus.FlagMask);
        return cur;
    endfunction

    function automatic logic modelTaken();
        logic [2:0] e;
        e = bypassFlags();
        if (rst || bus.Stall) return 1'b0;
        return (bus.JumpType == 3'd1 && e[0]) || (bus.JumpType == 3'd2 && e[1]) ||
               (bus.JumpType == 3'd3 && e[2]) || (bus.JumpType == 3'd4);
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [2:0] e;
        logic       t;
        if (rst) begin
            {mC, mN, mZ} = 3'b000;
            mStk.delete();
            mOvf = 1'b0; mUnf = 1'b0; mFlush = 1'b0;
        end else begin
            t = modelTaken();
            mFlush = t;
            if (!bus.Stall) begin
                e = bypassFlags();
                if (t && bus.JumpType == 3'd1) e[0] = 1'b0;
                if (t && bus.JumpType == 3'd2) e[1] = 1'b0;
                if (t && bus.JumpType == 3'd3) e[2] = 1'b0;
                if (bus.SetCarry) e[2] = 1'b1;
                if (bus.ClrCarry) e[2] = 1'b0;
                if (bus.IntRestore) begin
                    if (mStk.size() == 0) mUnf = 1'b1;
                    else e = mStk.pop_back();
                end else if (bus.IntSave) begin
                    if (mStk.size() == DEPTH) mOvf = 1'b1;
                    else mStk.push_back({mC, mN, mZ});
                end
                {mC, mN, mZ} = e;
            end
        end
    end

    task automatic cmp(input string name, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    logic running = 1'b1;
    always @(negedge clk) begin
        if (running) begin
            cmp("model.Flags", bus.Flags, {mC, mN, mZ});
            cmp("model.TakeBranch", {2'b0, bus.TakeBranch}, {2'b0, modelTaken()});
            cmp("model.FlushQ", {2'b0, bus.FlushQ}, {2'b0, mFlush});
            cmp("model.Overflow", {2'b0, bus.StackOverflow}, {2'b0, mOvf});
            cmp("model.Underflow", {2'b0, bus.StackUnderflow}, {2'b0, mUnf});
        end
    end

    task automatic idle();
        bus.Stall = 0; bus.newStatus = '0; bus.FlagWriteEn = 0; bus.FlagMask = '0;
        bus.SetCarry = 0; bus.ClrCarry = 0; bus.JumpType = '0;
        bus.IntSave = 0; bus.IntRestore = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic aluWr(input logic [3:0] st, input logic [2:0] mask);
        idle();
        bus.newStatus = st; bus.FlagWriteEn = 1; bus.FlagMask = mask;
    endtask

    initial begin
        idle();
        #12;
        rst = 0;
        #1;
        cmp("reset.Flags", bus.Flags, 3'b000);
        cyc();

        // 1: write Z, then JZ taken clears it and flushes
        aluWr(4'b1001, 3'b111); cyc();
        cmp("t1.Flags", bus.Flags, 3'b001);
        idle(); bus.JumpType = 3'b001; #2;
        cmp("t1.TakeBranch", {2'b0, bus.TakeBranch}, 3'b001);
        cyc();
        cmp("t1.FlagsAfter", bus.Flags, 3'b000);
        cmp("t1.FlushQ", {2'b0, bus.FlushQ}, 3'b001);

        // 2: same-cycle bypass into JN
        aluWr(4'b1010, 3'b111); bus.JumpType = 3'b010; #2;
        cmp("t2.TakeBranch", {2'b0, bus.TakeBranch}, 3'b001);
        cyc();
        cmp("t2.Flags", bus.Flags, 3'b000);

        // 3: mask and valid bit
        aluWr(4'b1111, 3'b111); cyc();
        aluWr(4'b1000, 3'b001); cyc();
        cmp("t3.Mask", bus.Flags, 3'b110);
        aluWr(4'b0000, 3'b111); cyc();
        cmp("t3.Invalid", bus.Flags, 3'b110);

        // 4: ClrCarry wins; stall blocks jump and holds flags
        idle(); bus.SetCarry = 1; bus.ClrCarry = 1; cyc();
        cmp("t4.CarryPrio", bus.Flags, 3'b010);
        idle(); bus.JumpType = 3'b100; cyc();
        cmp("t4.JmpFlush", {2'b0, bus.FlushQ}, 3'b001);
        idle(); bus.Stall = 1; bus.JumpType = 3'b100; bus.SetCarry = 1; #2;
        cmp("t4.StallTB", {2'b0, bus.TakeBranch}, 3'b000);
        cyc();
        cmp("t4.StallFlags", bus.Flags, 3'b010);
        cmp("t4.StallFlush", {2'b0, bus.FlushQ}, 3'b000);

        // 5: shadow stack fill, overflow, drain, underflow
        aluWr(4'b1101, 3'b111); cyc();
        idle(); bus.IntSave = 1; cyc();
        aluWr(4'b1010, 3'b111); cyc();
        idle(); bus.IntSave = 1; cyc();
        cmp("t5.NoOvfYet", {2'b0, bus.StackOverflow}, 3'b000);
        idle(); bus.IntSave = 1; cyc();
        cmp("t5.Overflow", {2'b0, bus.StackOverflow}, 3'b001);
        idle(); bus.IntRestore = 1; cyc();
        cmp("t5.Pop1", bus.Flags, 3'b010);
        cyc();
        cmp("t5.Pop2", bus.Flags, 3'b101);
        cyc();
        cmp("t5.Underflow", {2'b0, bus.StackUnderflow}, 3'b001);
        cmp("t5.Pop3", bus.Flags, 3'b101);

        // 6: async reset mid-cycle with pointer at 1
        aluWr(4'b1111, 3'b111); cyc();
        idle(); bus.IntSave = 1; cyc();
        idle(); bus.JumpType = 3'b100;
        #2; rst = 1; #1;
        cmp("t6.Flags", bus.Flags, 3'b000);
        cmp("t6.Errors", {1'b0, bus.StackOverflow, bus.StackUnderflow}, 3'b000);
        cmp("t6.TakeBranch", {2'b0, bus.TakeBranch}, 3'b000);
        cyc(); #2;
        idle(); rst = 0; cyc();

        // pointer is back at 0; simultaneous save/restore restores only
        idle(); bus.IntSave = 1; cyc();
        aluWr(4'b1110, 3'b111); cyc();
        idle(); bus.IntSave = 1; bus.IntRestore = 1; cyc();
        cmp("t7.Restore", bus.Flags, 3'b000);
        cmp("t7.NoOvf", {2'b0, bus.StackOverflow}, 3'b000);
        idle(); bus.IntRestore = 1; cyc();
        cmp("t7.Underflow", {2'b0, bus.StackUnderflow}, 3'b001);
        idle(); cyc();

        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/status_flag_unit.md
Name: status_flag_unit

Overview:
- Consumer end of the execute stage's 4-bit status output {valid, C, N, Z}.
- Holds the architectural condition-code register (CCR) and merges ALU status updates under a per-flag mask.
- Handles SETC/CLRC, resolves conditional jumps against bypassed flags, and saves/restores the CCR on interrupt entry/RTI through a small shadow stack.
- Sits between execute and fetch/decode; its outputs drive branch redirect and pipeline flush.

Parameters:
- STACK_DEPTH, 2, number of CCR shadow entries for nested interrupts (power of two, ≥1).
- PTR_W, 1, shadow pointer width; equals clog2(STACK_DEPTH), minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- Stall  input  1  freezes all state; forces TakeBranch low.
- newStatus  input  4  execute status {[3] valid, [2] C, [1] N, [0] Z}.
- FlagWriteEn  input  1  instruction updates flags.
- FlagMask  input  3  per-flag write enable {C, N, Z}.
- SetCarry  input  1  SETC.
- ClrCarry  input  1  CLRC.
- JumpType  input  3  000 none, 001 JZ, 010 JN, 011 JC, 100 JMP, others none.
- IntSave  input  1  push CCR (interrupt entry).
- IntRestore  input  1  pop CCR (RTI).
- Flags  output  3  CCR {C, N, Z}.
- TakeBranch  output  1  combinational: jump taken this cycle.
- FlushQ  output  1  registered copy of TakeBranch, one cycle later.
- StackOverflow  output  1  sticky: push while full.
- StackUnderflow  output  1  sticky: pop while empty.

Behaviour:
- Reset, asynchronous: Flags=000, shadow pointer=0, all shadow entries=000, FlushQ=0, StackOverflow=0, StackUnderflow=0. TakeBranch=0 while rst is high.
- ALU write is effective when FlagWriteEn && newStatus[3]. Masked merge: bit i of the merged value = FlagMask[i] ? newStatus[i] : Flags[i]. The valid bit is not stored.
- Bypass flags EF = merged value if the ALU write is effective, else Flags. Jumps resolve against EF in the same cycle, with zero-cycle latency.
- TakeBranch = !Stall && ((JZ && EF.Z) || (JN && EF.N) || (JC && EF.C) || JMP).
- Next-state order, each step applied on top of the previous one:
  1. Start from EF.
  2. If a conditional jump is taken, clear the tested flag (JMP clears nothing).
  3. SetCarry forces C=1. ClrCarry forces C=0. If both are asserted, ClrCarry wins.
  4. IntRestore, if the stack is non-empty, loads the popped entry and overrides all earlier steps.
- IntSave pushes the pre-edge Flags register value (not EF), then the pointer increments.
- IntSave and IntRestore in the same cycle: restore only; the push is ignored and no error is raised.
- Push while the pointer equals STACK_DEPTH: no write, pointer holds, StackOverflow is set. Pop at pointer 0: Flags follows the non-restore path, StackUnderflow is set.
- Sticky error bits clear only on rst.
- Stall: Flags, pointer, stack and error bits hold. FlushQ is loaded with 0.
- FlushQ <= TakeBranch on every non-reset edge.
- Reset mid-sequence: everything returns to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package holds:
  - JumpType encodings: JT_NONE, JT_JZ, JT_JN, JT_JC, JT_JMP.
  - Status bit index constants: ST_VALID=3, ST_C=2, ST_N=1, ST_Z=0.
  - 3-bit flags typedef.
- One sub-module: flag_shadow_stack (push/pop, pointer, full/empty, overflow/underflow detection), parameterised by STACK_DEPTH.
- Merge, branch resolution and priority logic stay in the top module.

Test Plan:
1. Reset, then newStatus=1001, FlagWriteEn=1, FlagMask=111 -> after the edge Flags=001; JumpType=JZ on the next cycle -> TakeBranch=1, then Flags=000 and FlushQ=1.
2. Bypass: Flags=000; in one cycle newStatus=1010 with mask 111 and JumpType=JN -> TakeBranch=1 that same cycle; after the edge Flags=000 (N set, then cleared by the taken jump).
3. Mask and valid bit: Flags=111; newStatus=1000 with mask 001 -> Flags=110. Then newStatus=0000 with mask 111 (valid=0) -> Flags remains 110.
4. Carry priority and Stall: SetCarry=1 and ClrCarry=1 together -> C=0. Stall=1 with JumpType=JMP and SetCarry=1 -> TakeBranch=0, Flags unchanged, FlushQ=0.
5. Stack: Flags=101 IntSave; Flags=010 IntSave; third IntSave -> StackOverflow=1. IntRestore -> Flags=010; IntRestore -> Flags=101; third IntRestore -> StackUnderflow=1, Flags=101.
6. Async reset: assert rst mid-cycle with Flags=111 and pointer=1 -> Flags=000, pointer=0 and errors=0 before the next clock edge; TakeBranch=0 while rst is high even with JumpType=JMP.
